// File: rtl/header_pkg.sv
// Shared types and constants for the load/store unit.
//   mem_size_t      : func3 access-size encodings (B, H, W, BU, HU)
//   lsu_state_t     : load/store sequencer states
//   TIMEOUT_DEFAULT : default number of REQ cycles before a bus access is aborted
//   normalize_size  : maps any 3-bit func3 onto a defined size (unknown codes act as W)
package header_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  localparam int TIMEOUT_DEFAULT = 16;

  function automatic mem_size_t normalize_size(input logic [2:0] code);
    case (code)
      3'b000:  return SZ_B;
      3'b001:  return SZ_H;
      3'b100:  return SZ_BU;
      3'b101:  return SZ_HU;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load-data extraction.
//   rdata  : 32-bit word returned by memory
//   offset : byte offset of the access within the word (addr[1:0])
//   size   : access size (normalized func3)
//   data   : lane-selected, sign- or zero-extended load result
module load_extract
  import header_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  mem_size_t   size,
  output logic [31:0] data
);

  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;
  logic signed [31:0] sext_b;
  logic signed [31:0] sext_h;

  always_comb begin
    lane_b = rdata[{offset, 3'b000} +: 8];
    // Halfword accesses are aligned, so only offset[1] selects the lane.
    lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
    sext_b = lane_b;
    sext_h = lane_h;
    case (size)
      SZ_B:    data = sext_b;
      SZ_H:    data = sext_h;
      SZ_BU:   data = {24'd0, lane_b};
      SZ_HU:   data = {16'd0, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns a load or store request from the pipeline into a
// single word-aligned bus access, with byte-lane steering for stores,
// extension of load data, misalignment detection and a bus timeout.
//   clk, rst_n           : clock, asynchronous active-low reset
//   rd_en, wr_en         : load / store request (both set -> store)
//   addr, wdata, size    : byte address, store data, func3 access size
//   load_data            : extended load result, non-zero only in DONE of a load
//   stall                : freeze PC / register write while an access is in flight
//   misalign, bus_err    : one-cycle error pulses
//   bus_req/we/addr/be/wdata : registered memory request
//   bus_rdata, bus_ack   : memory response
module load_store_unit
  import header_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  size,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  lsu_state_t       state;
  logic [CNT_W-1:0] cnt;
  mem_size_t        sz_in;
  mem_size_t        sz_q;
  logic [1:0]       off_q;
  logic             is_load_q;
  logic             misaligned;
  logic             accept;
  logic             timeout_hit;
  logic [3:0]       be_n;
  logic [31:0]      wdata_n;
  logic [31:0]      extracted;

  assign sz_in = normalize_size(size);

  always_comb begin
    misaligned = 1'b0;
    be_n       = 4'b1111;
    wdata_n    = wdata;
    case (sz_in)
      SZ_B, SZ_BU: begin
        be_n    = 4'b0001 << addr[1:0];
        wdata_n = {4{wdata[7:0]}};
      end
      SZ_H, SZ_HU: begin
        misaligned = addr[0];
        be_n       = addr[1] ? 4'b1100 : 4'b0011;
        wdata_n    = {2{wdata[15:0]}};
      end
      default: misaligned = (addr[1:0] != 2'b00);
    endcase
  end

  assign accept      = (state == ST_IDLE) && (rd_en || wr_en) && !misaligned;
  assign timeout_hit = (state == ST_REQ) && !bus_ack && (cnt == CNT_W'(TIMEOUT - 1));

  // Stall and the error pulses are decoded from the current cycle so the
  // pipeline freezes in the same cycle the request is presented; reset
  // masks them immediately.
  assign stall    = rst_n && (accept || (state == ST_REQ));
  assign misalign = rst_n && (state == ST_IDLE) && (rd_en || wr_en) && misaligned;
  assign bus_err  = rst_n && timeout_hit;

  load_extract u_load_extract (
    .rdata  (bus_rdata),
    .offset (off_q),
    .size   (sz_q),
    .data   (extracted)
  );

  // Access context used only for load extraction; no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      sz_q      <= sz_in;
      off_q     <= addr[1:0];
      is_load_q <= !wr_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      load_data <= '0;
    end else begin
      // load_data is only ever loaded on the REQ->DONE edge, so it is
      // visible for exactly the DONE cycle.
      load_data <= '0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_REQ;
            cnt       <= '0;
            bus_req   <= 1'b1;
            bus_we    <= wr_en;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be_n;
            bus_wdata <= wdata_n;
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            state   <= ST_DONE;
            bus_req <= 1'b0;
            if (is_load_q) load_data <= extracted;
          end else if (timeout_hit) begin
            state   <= ST_DONE;
            bus_req <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en, wr_en;
  logic [31:0] addr, wdata;
  logic [2:0]  size;
  logic [31:0] load_data;
  logic        stall, misalign, bus_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int errors = 0;
  int checks = 0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .addr      (addr),
    .wdata     (wdata),
    .size      (size),
    .load_data (load_data),
    .stall     (stall),
    .misalign  (misalign),
    .bus_err   (bus_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] c);
    if (c == 3'd0 || c == 3'd4) return 1;
    if (c == 3'd1 || c == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit model_misaligned(input logic [2:0] c, input logic [31:0] a);
    return (a % nbytes(c)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] c, input logic [31:0] a);
    int n = nbytes(c);
    if (n == 4) return 4'hF;
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] c, input logic [31:0] w);
    int n = nbytes(c);
    if (n == 1) return (w & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] c, input logic [31:0] a,
                                             input logic [31:0] rd);
    int n = nbytes(c);
    logic [31:0] v, mask;
    if (n == 4) return rd;
    mask = (32'd1 << (8 * n)) - 1;
    v = (rd >> (8 * (a % 4))) & mask;
    if ((c == 3'd0 || c == 3'd1) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // One complete access starting in IDLE, #1 after a rising edge.
  // ack_delay = index of the REQ cycle carrying the ack (>= TO means never).
  task automatic run_access(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] w, input logic [2:0] c,
                            input logic [31:0] rdat, input int ack_delay);
    bit store = wr;
    bit done  = 0;
    bit timed_out = (ack_delay >= TO);
    rd_en = rd; wr_en = wr; addr = a; wdata = w; size = c;
    bus_ack = 1'b0; bus_rdata = $urandom;
    if (!rd && !wr) begin
      bus_ack = 1'b1;  // stray ack in IDLE must be ignored
      @(negedge clk);
      check_val("idle_stall", stall, 0);
      check_val("idle_breq", bus_req, 0);
      @(posedge clk); #1;
      bus_ack = 1'b0;
      @(negedge clk);
      check_val("idle_after_ack_breq", bus_req, 0);
      @(posedge clk); #1;
      return;
    end
    @(negedge clk);
    if (model_misaligned(c, a)) begin
      check_val("mis_pulse", misalign, 1);
      check_val("mis_stall", stall, 0);
      check_val("mis_ldata", load_data, 0);
      check_val("mis_breq", bus_req, 0);
      @(posedge clk); #1;
      rd_en = 0; wr_en = 0;
      @(negedge clk);
      check_val("mis_after_breq", bus_req, 0);
      check_val("mis_after_pulse", misalign, 0);
      @(posedge clk); #1;
      return;
    end
    check_val("idle_req_stall", stall, 1);
    check_val("idle_req_mis", misalign, 0);
    check_val("idle_req_breq", bus_req, 0);
    @(posedge clk); #1;
    for (int k = 0; k < TO && !done; k++) begin
      if (k == ack_delay) begin bus_ack = 1'b1; bus_rdata = rdat; end
      else begin bus_ack = 1'b0; bus_rdata = $urandom; end
      @(negedge clk);
      check_val("req_breq", bus_req, 1);
      check_val("req_stall", stall, 1);
      check_val("req_addr", bus_addr, a & 32'hFFFF_FFFC);
      check_val("req_we", bus_we, store);
      check_val("req_be", bus_be, model_be(c, a));
      if (store) check_val("req_wdata", bus_wdata, model_wdata(c, w));
      check_val("req_err", bus_err, (k == TO - 1) && (k != ack_delay));
      check_val("req_ldata", load_data, 0);
      @(posedge clk); #1;
      if (k == ack_delay || k == TO - 1) done = 1;
    end
    // DONE cycle: a stray ack here must also be ignored
    bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    rd_en = 0; wr_en = 0;
    @(negedge clk);
    check_val("done_stall", stall, 0);
    check_val("done_breq", bus_req, 0);
    check_val("done_err", bus_err, 0);
    check_val("done_ldata", load_data,
              (!store && !timed_out) ? model_load(c, a, rdat) : 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    check_val("back_idle_ldata", load_data, 0);
    check_val("back_idle_stall", stall, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rd_en = 1'b1; wr_en = 1'b0; addr = 32'h100; wdata = '0;
    size = 3'd2; bus_rdata = '0; bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_breq", bus_req, 0);
    check_val("rst_stall", stall, 0);
    check_val("rst_be", bus_be, 0);
    check_val("rst_addr", bus_addr, 0);
    check_val("rst_wdata", bus_wdata, 0);
    check_val("rst_ldata", load_data, 0);
    check_val("rst_mis", misalign, 0);
    check_val("rst_err", bus_err, 0);
    check_val("rst_we", bus_we, 0);
    @(posedge clk); #1;
    rd_en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_access(0, 1, 32'h104, 32'hDEADBEEF, 3'd2, 32'h0, 0);      // SW
    run_access(0, 1, 32'h103, 32'h000000A5, 3'd0, 32'h0, 1);      // SB
    run_access(1, 0, 32'h202, 32'h0, 3'd0, 32'h1280FF00, 0);      // LB
    run_access(1, 0, 32'h202, 32'h0, 3'd4, 32'h1280FF00, 2);      // LBU
    run_access(1, 0, 32'h202, 32'h0, 3'd5, 32'h1280FF00, 0);      // LHU
    run_access(1, 0, 32'h105, 32'h0, 3'd2, 32'h0, 0);             // LW misaligned
    run_access(1, 0, 32'h200, 32'h0, 3'd2, 32'h12345678, TO + 5); // timeout
    run_access(1, 1, 32'h30A, 32'h0000BEEF, 3'd1, 32'hFFFFFFFF, 1); // rd+wr -> store
    run_access(1, 0, 32'h400, 32'h0, 3'd7, 32'h89ABCDEF, 3);      // undefined size -> W

    // Reset in the middle of a REQ, ack arrives after release
    rd_en = 1; wr_en = 0; addr = 32'h300; size = 3'd2;
    @(negedge clk);
    check_val("rstmid_idle_stall", stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rstmid_req_breq", bus_req, 1);
    #1 rst_n = 1'b0;
    #1;
    check_val("rstmid_breq_now", bus_req, 0);
    check_val("rstmid_stall_now", stall, 0);
    check_val("rstmid_be_now", bus_be, 0);
    @(posedge clk); #1;
    rd_en = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check_val("rstmid_ack_breq", bus_req, 0);
    check_val("rstmid_ack_stall", stall, 0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    check_val("rstmid_ack_ldata", load_data, 0);
    check_val("rstmid_ack_err", bus_err, 0);
    @(posedge clk); #1;

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      logic [1:0]  rw;
      logic [31:0] a;
      int          dly;
      rw  = 2'($urandom_range(0, 3));
      a   = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      dly = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 4));
      run_access(rw[0], rw[1], a, $urandom, 3'($urandom_range(0, 7)), $urandom, dly);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 rd_en, wr_en  in  1 each  load / store request from control, held stable while stall=1.
REQ-005 addr  in  32  byte address from ALU output; wdata  in  32  store data from rs2.
REQ-006 size  in  3  func3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 load_data  out  32  extended load result, consumed by write-back mux; stall  out  1  freeze PC and register write.
REQ-008 misalign  out  1  one-cycle pulse for misaligned access; bus_err  out  1  one-cycle pulse on bus timeout.
REQ-009 bus_req  out  1; bus_we  out  1; bus_addr  out  32 (word-aligned, [1:0]=00); bus_be  out  4; bus_wdata  out  32.
REQ-010 bus_rdata  in  32; bus_ack  in  1  one-cycle completion strobe from memory.
REQ-011 TIMEOUT  parameter  default 16  max cycles in REQ before abort.

Function
REQ-012 FSM states: IDLE, REQ, DONE.
REQ-013 IDLE: on (rd_en|wr_en) with an aligned access, register address, byte enables, aligned wdata and size, then go to REQ; stall=1 that cycle.
REQ-014 wr_en and rd_en together: treated as store.
REQ-015 Misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0): no bus request, misalign=1 for that cycle, stall=0, load_data=0, remain IDLE.
REQ-016 REQ: bus_req=1 registered, bus_we/addr/be/wdata held constant; stall=1.
REQ-017 REQ with bus_ack=1: capture bus_rdata, go to DONE.
REQ-018 DONE: stall=0, load_data valid for exactly this cycle, then go to IDLE; minimum latency is 3 cycles from request to stall=0.
REQ-019 bus_ack in IDLE or DONE SHALL be ignored.
REQ-020 Timeout counter clears on entry to REQ; when it reaches TIMEOUT-1 without ack: bus_err=1, bus_req drops, go to DONE with load_data=0 and no write-back data.
REQ-021 Store alignment: B -> be=0001<<addr[1:0], byte replicated in all 4 lanes; H -> be=0011 (addr[1]=0) or 1100, halfword replicated; W -> be=1111.
REQ-022 Load extraction: select lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W passthrough.
REQ-023 Undefined size codes SHALL behave as W.
REQ-024 load_data=0 in all cycles other than DONE of a load.

Reset
REQ-025 Reset assertion SHALL immediately force IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, stall=0, misalign=0, bus_err=0, load_data=0, counter=0.
REQ-026 Reset mid-transaction SHALL abandon the access; a later bus_ack is ignored.

Structure
REQ-027 header_pkg SHALL hold mem_size_t (func3 encodings), lsu_state_t, and the default TIMEOUT constant.
REQ-028 One combinational sub-module, load_extract, SHALL implement REQ-022; store alignment stays inline.

Verification
REQ-029 SW addr=0x104 wdata=0xDEADBEEF, ack on first REQ cycle -> bus_addr=0x104, be=1111, stall high 2 cycles, low on third.
REQ-030 SB addr=0x103 wdata=0x000000A5 -> be=1000, bus_wdata=0xA5A5A5A5.
REQ-031 LB addr=0x202, bus_rdata=0x1280FF00 -> load_data=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x202 -> 0x00001280.
REQ-032 LW addr=0x105 -> misalign pulse, bus_req never asserted, stall=0.
REQ-033 Load with no ack for 16 cycles -> bus_err pulse on 16th REQ cycle, load_data=0, return to IDLE.
REQ-034 Reset asserted during REQ, ack arrives 2 cycles after release -> bus_req=0 immediately, FSM IDLE, ack ignored.
